tlight_ped: RTL and testbench
=============================

Name: tlight_ped

Overview:
- Parametrised successor to the fixed-timing two-road traffic light (NS/WE approaches).
- Phase durations are parameters.
- Adds a pedestrian request input with an all-red WALK phase and green-shortening.
- Moore FSM with one phase counter; sits at top of traffic-light example, driving lamp outputs.

Parameters:
- T_GREEN, 16, green duration in cycles (>=1)
- T_GREEN_MIN, 6, minimum green before a pending pedestrian request may cut it (1..T_GREEN)
- T_YELLOW, 4, yellow duration in cycles (>=1)
- T_ALLRED, 2, all-red clearance duration in cycles (>=1)
- T_WALK, 8, pedestrian walk duration in cycles (>=1)
- CW, $clog2(max of all T_*)+1, phase counter width (derived localparam)

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  synchronous active-high reset
- ped_req  input  1  pedestrian button; level or pulse, sampled each edge
- ns  output  3  NS lamps {red,yellow,green}
- we  output  3  WE lamps {red,yellow,green}
- walk  output  1  pedestrian walk lamp
- ped_wait  output  1  request latched, not yet served

Behaviour:
- Interface: one clock `clock`; `reset` synchronous, active-high; all state updates on posedge clock.
- States: NS_GREEN, NS_YELLOW, RED1, WALK1, WE_GREEN, WE_YELLOW, RED2, WALK2.
- Outputs are pure decodes of state (Moore), no extra latency:
  - NS_GREEN: ns=001, we=100
  - NS_YELLOW: ns=010, we=100
  - WE_GREEN: ns=100, we=001
  - WE_YELLOW: ns=100, we=010
  - RED1, RED2, WALK1, WALK2: ns=100, we=100
  - walk=1 only in WALK1/WALK2
- Reset: state=NS_GREEN, cnt=0, ped latch=0. So ns=001, we=100, walk=0, ped_wait=0 on the first edge after reset and while reset is held.
- Reset asserted mid-phase aborts the phase immediately (next edge).
- Phase timing:
  - cnt counts 0..D-1 within a phase of duration D.
  - Transition occurs on the edge where cnt==D-1; cnt returns to 0.
  - Every phase lasts exactly D cycles.
- Transition sequence:
  - NS_GREEN -> NS_YELLOW -> RED1 -> (WALK1 if ped latch, else WE_GREEN)
  - WALK1 -> WE_GREEN -> WE_YELLOW -> RED2 -> (WALK2 if ped latch, else NS_GREEN)
  - WALK2 -> NS_GREEN
- Green shortening: in NS_GREEN/WE_GREEN with ped latch=1, green ends on the edge where cnt==T_GREEN_MIN-1. If the request latches after that point, green ends on the next edge.
- Ped latch:
  - Set by ped_req=1 on any edge.
  - Cleared on the edge entering WALK1/WALK2.
  - If set and clear coincide, set wins: a request in the entry cycle is served next walk.
  - ped_wait = latch.
- Without any request, the full cycle is 2*(T_GREEN+T_YELLOW+T_ALLRED) cycles (44 default).
- Invariants (bench asserts):
  - never both ns and we non-red
  - exactly one lamp bit per approach
  - walk implies ns=we=100
- Elaboration check: $error if any T_* <1 or T_GREEN_MIN>T_GREEN.

Optional Feature:
- Macro TLIGHT_NIGHT_EN.
- When defined:
  - Adds input port `night` (1 bit) and parameter T_FLASH (default 4).
  - night=1 on any edge -> state NIGHT next edge; ped latch cleared and ignored.
  - In NIGHT: ns=we={0,flash,0}, walk=0. flash starts 1 on entry and toggles every T_FLASH cycles.
  - night=0 in NIGHT -> RED2 (full T_ALLRED, no walk) -> NS_GREEN.
  - Reset overrides night.
- When undefined: no `night` port, no NIGHT state; behaviour exactly as above.

Decomposition:
- Package tlight_pkg:
  - state_t enum
  - lamp constants RED=3'b100, YELLOW=3'b010, GREEN=3'b001, DARK=3'b000
- Sub-module tlight_timer:
  - parameter CW; inputs clock, reset, clr, len[CW-1:0]; output done (cnt==len-1)
  - FSM asserts clr on every transition.

Test Plan:
- Reset 1 cycle then release -> first edge ns=001/we=100; NS_GREEN lasts 16 cycles, NS_YELLOW 4, RED1 2, WE_GREEN 16; period 44.
- ped_req pulse at cnt=2 of NS_GREEN -> ped_wait=1; green ends after 6 cycles; 4 yellow, 2 all-red, walk=1 for 8 cycles, then WE_GREEN full 16; ped_wait=0 on WALK1 entry.
- ped_req pulse at cnt=10 of WE_GREEN -> green ends next edge (11 cycles total), then WE_YELLOW, RED2, WALK2, NS_GREEN.
- ped_req held high continuously -> every green shortened to 6 and a walk follows every all-red; period 2*(6+4+2+8)=40.
- Reset asserted in WE_YELLOW cnt=1 -> next edge NS_GREEN, ped_wait=0.
- (TLIGHT_NIGHT_EN) night=1 during WE_GREEN -> NIGHT, ns=we=010 for 4 cycles, then 000 for 4; night=0 -> RED2 for 2 cycles, then NS_GREEN.

Source files
------------

// File: rtl/tlight_pkg.sv
// tlight_pkg: shared state encoding, lamp patterns and helpers for the
// pedestrian traffic-light controller.
// Optional build macro: TLIGHT_NIGHT_EN (adds the NIGHT flashing state).
package tlight_pkg;

  typedef enum logic [3:0] {
    NS_GREEN,
    NS_YELLOW,
    RED1,
    WALK1,
    WE_GREEN,
    WE_YELLOW,
    RED2,
    WALK2
`ifdef TLIGHT_NIGHT_EN
    ,
    NIGHT
`endif
  } state_t;

  // Lamp vectors are {red,yellow,green}
  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] DARK   = 3'b000;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tlight_timer.sv
// tlight_timer: phase counter shared by every phase of the controller.
// Counts up from 0 each cycle; clr restarts it at 0 on the next edge.
// done flags the last cycle of a phase of length len.
// Optional build macro: TLIGHT_NIGHT_EN (no effect in this file).
module tlight_timer #(
  parameter int CW = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clr,
  input  logic [CW-1:0] len,
  output logic          done,
  output logic [CW-1:0] cnt
);

  // Phase counter: restart on reset or on any phase change
  always_ff @(posedge clock) begin
    if (reset || clr) cnt <= '0;
    else              cnt <= cnt + 1'b1;
  end

  assign done = (cnt == len - 1'b1);

endmodule

// File: rtl/tlight_ped.sv
// tlight_ped: two-road traffic light with pedestrian walk phase and
// green shortening. Moore outputs decoded from the state register.
// Optional build macro: TLIGHT_NIGHT_EN (adds night input and the NIGHT
// flashing-yellow state).
module tlight_ped
  import tlight_pkg::*;
#(
  parameter int T_GREEN     = 16,
  parameter int T_GREEN_MIN = 6,
  parameter int T_YELLOW    = 4,
  parameter int T_ALLRED    = 2,
  parameter int T_WALK      = 8
`ifdef TLIGHT_NIGHT_EN
  ,
  parameter int T_FLASH     = 4
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ped_req,
`ifdef TLIGHT_NIGHT_EN
  input  logic       night,
`endif
  output logic [2:0] ns,
  output logic [2:0] we,
  output logic       walk,
  output logic       ped_wait
);

`ifdef TLIGHT_NIGHT_EN
  localparam int TMAX = max2(max2(max2(T_GREEN, T_YELLOW), max2(T_ALLRED, T_WALK)), T_FLASH);
`else
  localparam int TMAX = max2(max2(T_GREEN, T_YELLOW), max2(T_ALLRED, T_WALK));
`endif
  localparam int CW = $clog2(TMAX) + 1;
  localparam logic [CW-1:0] GMIN_LAST = CW'(T_GREEN_MIN - 1);

  if (T_GREEN < 1 || T_YELLOW < 1 || T_ALLRED < 1 || T_WALK < 1) begin : g_bad_dur
    $error("tlight_ped: every phase duration must be >= 1");
  end
  if (T_GREEN_MIN < 1 || T_GREEN_MIN > T_GREEN) begin : g_bad_gmin
    $error("tlight_ped: T_GREEN_MIN must lie in 1..T_GREEN");
  end
`ifdef TLIGHT_NIGHT_EN
  if (T_FLASH < 1) begin : g_bad_flash
    $error("tlight_ped: T_FLASH must be >= 1");
  end
`endif

  state_t        state, nxt;
  logic          ped_lat;
  logic          clr, done;
  logic [CW-1:0] len, cnt;
  logic          pend;

`ifdef TLIGHT_NIGHT_EN
  logic          flash;
  logic          night_exit;
`endif

  tlight_timer #(.CW(CW)) u_timer (
    .clock (clock),
    .reset (reset),
    .clr   (clr),
    .len   (len),
    .done  (done),
    .cnt   (cnt)
  );

  // A request arriving on the cut-off edge itself already counts, so a
  // late press ends green on the very edge it is sampled.
  assign pend = ped_lat | ped_req;

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= NS_GREEN;
    else       state <= nxt;
  end

  // Pedestrian latch: set wins over the clear on walk entry
  always_ff @(posedge clock) begin
    if (reset)                                            ped_lat <= 1'b0;
`ifdef TLIGHT_NIGHT_EN
    else if (night || state == NIGHT)                     ped_lat <= 1'b0;
`endif
    else if (ped_req)                                     ped_lat <= 1'b1;
    else if ((nxt == WALK1 || nxt == WALK2) && nxt != state) ped_lat <= 1'b0;
  end

`ifdef TLIGHT_NIGHT_EN
  // Flash phase toggles each T_FLASH cycles; marks the walk-free RED2 after night
  always_ff @(posedge clock) begin
    if (reset) begin
      flash      <= 1'b0;
      night_exit <= 1'b0;
    end else begin
      if (nxt == NIGHT && state != NIGHT)  flash <= 1'b1;
      else if (state == NIGHT && done)     flash <= ~flash;
      if (state == NIGHT && nxt == RED2)   night_exit <= 1'b1;
      else if (state == RED2 && nxt != RED2) night_exit <= 1'b0;
    end
  end
`endif

  // Next-state, phase length and timer restart
  always_comb begin
    nxt = state;
    len = CW'(T_GREEN);
    unique case (state)
      NS_GREEN: begin
        len = CW'(T_GREEN);
        if (done || (pend && cnt >= GMIN_LAST)) nxt = NS_YELLOW;
      end
      NS_YELLOW: begin
        len = CW'(T_YELLOW);
        if (done) nxt = RED1;
      end
      RED1: begin
        len = CW'(T_ALLRED);
        if (done) nxt = ped_lat ? WALK1 : WE_GREEN;
      end
      WALK1: begin
        len = CW'(T_WALK);
        if (done) nxt = WE_GREEN;
      end
      WE_GREEN: begin
        len = CW'(T_GREEN);
        if (done || (pend && cnt >= GMIN_LAST)) nxt = WE_YELLOW;
      end
      WE_YELLOW: begin
        len = CW'(T_YELLOW);
        if (done) nxt = RED2;
      end
      RED2: begin
        len = CW'(T_ALLRED);
`ifdef TLIGHT_NIGHT_EN
        if (done) nxt = (ped_lat && !night_exit) ? WALK2 : NS_GREEN;
`else
        if (done) nxt = ped_lat ? WALK2 : NS_GREEN;
`endif
      end
      WALK2: begin
        len = CW'(T_WALK);
        if (done) nxt = NS_GREEN;
      end
`ifdef TLIGHT_NIGHT_EN
      NIGHT: begin
        len = CW'(T_FLASH);
        if (!night) nxt = RED2;
      end
`endif
      default: nxt = NS_GREEN;
    endcase
`ifdef TLIGHT_NIGHT_EN
    if (night) nxt = NIGHT;
`endif
    clr = (nxt != state);
`ifdef TLIGHT_NIGHT_EN
    if (state == NIGHT && done) clr = 1'b1;
`endif
  end

  // Lamp decode
  always_comb begin
    ns   = RED;
    we   = RED;
    walk = 1'b0;
    case (state)
      NS_GREEN:     ns = GREEN;
      NS_YELLOW:    ns = YELLOW;
      WE_GREEN:     we = GREEN;
      WE_YELLOW:    we = YELLOW;
      WALK1, WALK2: walk = 1'b1;
`ifdef TLIGHT_NIGHT_EN
      NIGHT: begin
        ns = {1'b0, flash, 1'b0};
        we = {1'b0, flash, 1'b0};
      end
`endif
      default: ;
    endcase
  end

  assign ped_wait = ped_lat;

endmodule

// File: tb/tb_tlight_ped.sv
// tb_tlight_ped: directed plus randomized checks of tlight_ped against a
// phase-table reference model.
module tb_tlight_ped;
  import tlight_pkg::*;

  localparam int TG  = 16;
  localparam int TGM = 6;
  localparam int TY  = 4;
  localparam int TA  = 2;
  localparam int TW  = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ped_req = 1'b0;
  logic [2:0] ns, we;
  logic       walk, ped_wait;
`ifdef TLIGHT_NIGHT_EN
  logic       night = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  tlight_ped #(
    .T_GREEN(TG), .T_GREEN_MIN(TGM), .T_YELLOW(TY), .T_ALLRED(TA), .T_WALK(TW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .ped_req  (ped_req),
`ifdef TLIGHT_NIGHT_EN
    .night    (night),
`endif
    .ns       (ns),
    .we       (we),
    .walk     (walk),
    .ped_wait (ped_wait)
  );

  always #5 clock = ~clock;

  // Reference model: phase index into the cycle NSG,NSY,R1,W1,WEG,WEY,R2,W2
  int m_ph = 0;
  int m_el = 0;
  bit m_lat = 1'b0;
  logic [2:0] ns_tab [8] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] we_tab [8] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100};

  function automatic int dur(input int p);
    case (p)
      0, 4:    return TG;
      1, 5:    return TY;
      2, 6:    return TA;
      default: return TW;
    endcase
  endfunction

  task automatic model_edge(input bit r, input bit req);
    bit fin;
    int nph;
    if (r) begin
      m_ph = 0; m_el = 0; m_lat = 1'b0;
    end else begin
      fin = (m_el == dur(m_ph) - 1) ||
            ((m_ph == 0 || m_ph == 4) && (m_lat || req) && m_el >= TGM - 1);
      nph = m_ph;
      if (fin) begin
        if (m_ph == 2)      nph = m_lat ? 3 : 4;
        else if (m_ph == 6) nph = m_lat ? 7 : 0;
        else                nph = (m_ph + 1) % 8;
      end
      if (req)                          m_lat = 1'b1;
      else if (fin && (nph == 3 || nph == 7)) m_lat = 1'b0;
      m_el = fin ? 0 : m_el + 1;
      m_ph = nph;
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] got, input logic [2:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chki(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk3("ns", ns, ns_tab[m_ph]);
    chk3("we", we, we_tab[m_ph]);
    chk1("walk", walk, (m_ph == 3 || m_ph == 7));
    chk1("ped_wait", ped_wait, m_lat);
    chk1("inv_both_go", (ns !== RED) && (we !== RED), 1'b0);
    chk1("inv_onehot", ($countones(ns) == 1) && ($countones(we) == 1), 1'b1);
    chk1("inv_walk_red", walk && ((ns !== RED) || (we !== RED)), 1'b0);
  endtask

  task automatic step(input bit r, input bit req);
    reset   = r;
    ped_req = req;
    @(posedge clock);
    model_edge(r, req);
    #1;
    check_all();
  endtask

  // Length of the phase currently shown, counting the present cycle; on
  // return the bench sits in the first cycle of the following phase.
  task automatic count_phase(input bit req, output int n);
    logic [6:0] cur;
    cur = {ns, we, walk};
    n = 1;
    for (int k = 0; k < 100; k++) begin
      step(1'b0, req);
      if ({ns, we, walk} !== cur) return;
      n++;
    end
    tests++;
    fails++;
    $error("FAIL phase_timeout: got >%0d cycles expected a lamp change", n);
  endtask

  initial begin
    int n, g, sum;

    // Reset held
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk3("rst_ns", ns, GREEN);
    chk3("rst_we", we, RED);
    chk1("rst_walk", walk, 1'b0);
    chk1("rst_wait", ped_wait, 1'b0);

    // Free-running cycle, no requests
    sum = 0;
    count_phase(1'b0, n); chki("ns_green_len", n, TG);  sum += n;
    count_phase(1'b0, n); chki("ns_yellow_len", n, TY); sum += n;
    count_phase(1'b0, n); chki("red1_len", n, TA);      sum += n;
    count_phase(1'b0, n); chki("we_green_len", n, TG);  sum += n;
    count_phase(1'b0, n); chki("we_yellow_len", n, TY); sum += n;
    count_phase(1'b0, n); chki("red2_len", n, TA);      sum += n;
    chki("period_noreq", sum, 44);

    // Pulse at cnt=2 of NS_GREEN
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk1("pulse_wait", ped_wait, 1'b1);
    count_phase(1'b0, n); chki("short_green", n + 3, TGM);
    count_phase(1'b0, n); chki("short_yellow", n, TY);
    count_phase(1'b0, n); chki("short_red1", n, TA);
    chk1("walk1_on", walk, 1'b1);
    chk1("walk1_wait_clr", ped_wait, 1'b0);
    count_phase(1'b0, n); chki("walk1_len", n, TW);
    count_phase(1'b0, n); chki("we_green_full", n, TG);
    count_phase(1'b0, n);
    count_phase(1'b0, n);
    count_phase(1'b0, n);
    count_phase(1'b0, n);
    count_phase(1'b0, n);

    // Pulse at cnt=10 of WE_GREEN: green ends on that edge
    chk3("we_green_start", we, GREEN);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk3("late_cut_we", we, YELLOW);
    count_phase(1'b0, n); chki("late_yellow", n, TY);
    count_phase(1'b0, n); chki("late_red2", n, TA);
    chk1("walk2_on", walk, 1'b1);
    count_phase(1'b0, n); chki("walk2_len", n, TW);
    chk3("after_walk2_ns", ns, GREEN);

    // Request held high: period 40
    sum = 0;
    for (int k = 0; k < 8; k++) begin
      count_phase(1'b1, n);
      sum += n;
    end
    chki("period_held", sum, 2 * (TGM + TY + TA + TW));

    // Reset in WE_YELLOW cnt=1 with a pending request
    g = 0;
    while (!(m_ph == 5 && m_el == 1) && g < 200) begin
      step(1'b0, (m_ph == 4 && m_el == 0));
      g++;
    end
    chk1("pre_rst_wait", ped_wait, 1'b1);
    step(1'b1, 1'b0);
    chk3("mid_rst_ns", ns, GREEN);
    chk1("mid_rst_wait", ped_wait, 1'b0);

    // Randomized requests and occasional resets
    for (int k = 0; k < 1500; k++) begin
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 11) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
